// File: rtl/sifh_pkg.sv
// sifh_pkg: shared defaults, FSM states, pipeline stage type and saturating increment for the histogram engine
package sifh_pkg;
    localparam int DEF_NP       = 10;
    localparam int DEF_NB       = 10;
    localparam int DEF_PEAK_MAX = 8;
    localparam int DEF_PIXELS   = 4;
    localparam int DEF_PB       = (DEF_PIXELS > 1) ? $clog2(DEF_PIXELS) : 1;
    localparam int DEF_AW       = DEF_PB + DEF_NB;
    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;
    typedef struct packed {
        logic                    valid;
        logic [DEF_AW-1:0]       addr;
        logic [DEF_PEAK_MAX-1:0] count;
    } stage_t;
    function automatic logic [DEF_PEAK_MAX-1:0] sat_inc(input logic [DEF_PEAK_MAX-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/sifh_peak_tracker.sv
// sifh_peak_tracker: per-pixel running peak bank with a registered readout mux
module sifh_peak_tracker #(
    parameter int PB = 2,
    parameter int NB = 10,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_clr,
    input  logic          i_upd,
    input  logic [PB-1:0] i_pix,
    input  logic [NB-1:0] i_bin,
    input  logic [CW-1:0] i_count,
    input  logic [PB-1:0] i_sel,
    output logic [NB-1:0] o_peak_bin,
    output logic [CW-1:0] o_peak_count
);
    localparam int N = 1 << PB;
    logic [NB-1:0] r_bin [N];
    logic [CW-1:0] r_cnt [N];
    logic [NB-1:0] r_peak_bin;
    logic [CW-1:0] r_peak_count;
    assign o_peak_bin   = r_peak_bin;
    assign o_peak_count = r_peak_count;
    // Strictly-greater update keeps the earliest bin on ties; clear or reset zeroes the bank
    always_ff @(posedge i_clk)
        if (!i_res || i_clr)
            for (int i = 0; i < N; i++) begin
                r_bin[i] <= '0;
                r_cnt[i] <= '0;
            end
        else if (i_upd && i_count > r_cnt[i_pix]) begin
            r_bin[i_pix] <= i_bin;
            r_cnt[i_pix] <= i_count;
        end
    // Readout samples the bank as it stood before this edge
    always_ff @(posedge i_clk)
        if (!i_res) begin
            r_peak_bin   <= '0;
            r_peak_count <= '0;
        end else begin
            r_peak_bin   <= r_bin[i_sel];
            r_peak_count <= r_cnt[i_sel];
        end
endmodule

// File: rtl/sifh_hist_rmw.sv
// sifh_hist_rmw: pipelined histogram read-modify-write engine with forwarding, saturation, clear sweep and peak tracking
module sifh_hist_rmw
    import sifh_pkg::*;
#(
    parameter int NP       = DEF_NP,
    parameter int NB       = DEF_NB,
    parameter int PEAK_MAX = DEF_PEAK_MAX,
    parameter int PIXELS   = DEF_PIXELS,
    localparam int PB      = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_res,
    input  logic                i_wrEn,
    input  logic [PB-1:0]       i_pix,
    input  logic [NP-1:0]       i_data,
    output logic                o_ready,
    input  logic                i_clear_start,
    output logic                o_clear_done,
    output logic [PB+NB-1:0]    o_raddr,
    output logic                o_readFlag,
    output logic                o_rEnable,
    input  logic [PEAK_MAX-1:0] i_counts,
    output logic [PB+NB-1:0]    o_waddr,
    output logic                o_writeFlag,
    output logic                o_wEnable,
    output logic [PEAK_MAX-1:0] o_newCounts,
    output logic                o_sat,
    input  logic [PB-1:0]       i_peak_pix,
    output logic [NB-1:0]       o_peak_bin,
    output logic [PEAK_MAX-1:0] o_peak_count
);
    localparam int AW = PB + NB;
    localparam logic [AW:0] SWEEP_END = (AW+1)'(PIXELS << NB);
    state_t              r_state;
    logic [AW:0]         r_cnt;
    logic                r_ready, r_clear_done, r_rv, r_mv, r_sat;
    logic [AW-1:0]       r_ra, r_ma;
    stage_t              r_w, r_w2;
    logic                w_ready, w_acc, w_clr_wr, w_clr;
    logic [PEAK_MAX-1:0] w_base;
    assign w_ready      = r_ready & ~i_clear_start;
    assign w_acc        = i_wrEn & w_ready;
    assign w_clr        = r_state == CLEAR;
    assign w_clr_wr     = w_clr && r_cnt != SWEEP_END;
    assign o_ready      = w_ready;
    assign o_clear_done = r_clear_done;
    assign o_raddr      = r_ra;
    assign o_readFlag   = r_rv;
    assign o_rEnable    = ~r_rv;
    assign o_waddr      = r_w.addr;
    assign o_writeFlag  = r_w.valid;
    assign o_wEnable    = r_w.valid;
    assign o_newCounts  = r_w.count;
    assign o_sat        = r_sat;
    // Control FSM: sweep the RAM to zero, run, then drain the pipeline before the next sweep
    always_ff @(posedge i_clk)
        if (!i_res) begin
            r_state      <= CLEAR;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                CLEAR:
                    if (r_cnt == SWEEP_END) begin
                        r_state      <= RUN;
                        r_cnt        <= '0;
                        r_ready      <= 1'b1;
                        r_clear_done <= 1'b1;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                RUN:
                    if (i_clear_start) begin
                        r_state <= DRAIN;
                        r_ready <= 1'b0;
                    end
                DRAIN:
                    if (!(r_rv || r_mv || r_w.valid))
                        r_state <= CLEAR;
                default: r_state <= CLEAR;
            endcase
        end
    // Read-first RAM misses the two most recent writes, so take the newest matching one in flight
    always_comb
        w_base = (r_w.valid && r_w.addr == r_ma) ? r_w.count :
                 (r_w2.valid && r_w2.addr == r_ma) ? r_w2.count : i_counts;
    // R -> M -> W pipeline; the write stage is borrowed by the clear sweep
    always_ff @(posedge i_clk)
        if (!i_res) begin
            r_rv  <= 1'b0;
            r_ra  <= '0;
            r_mv  <= 1'b0;
            r_ma  <= '0;
            r_w   <= '0;
            r_w2  <= '0;
            r_sat <= 1'b0;
        end else begin
            r_rv  <= w_acc;
            r_ra  <= {i_pix, i_data[NP-1 -: NB]};
            r_mv  <= r_rv;
            r_ma  <= r_ra;
            r_w   <= w_clr_wr ? stage_t'{valid: 1'b1, addr: r_cnt[AW-1:0], count: '0}
                              : stage_t'{valid: r_mv, addr: r_ma, count: sat_inc(w_base)};
            r_w2  <= r_w;
            r_sat <= w_clr ? 1'b0 : r_sat | (r_mv & (&w_base));
        end
    sifh_peak_tracker #(.PB(PB), .NB(NB), .CW(PEAK_MAX)) u_peak (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_clr       (w_clr),
        .i_upd       (r_w.valid),
        .i_pix       (r_w.addr[AW-1:NB]),
        .i_bin       (r_w.addr[NB-1:0]),
        .i_count     (r_w.count),
        .i_sel       (i_peak_pix),
        .o_peak_bin  (o_peak_bin),
        .o_peak_count(o_peak_count)
    );
endmodule

// File: tb/tb_sifh_hist_rmw.sv
// tb_sifh_hist_rmw: randomized scoreboard bench for the histogram read-modify-write engine
module tb_sifh_hist_rmw;
    localparam int PM    = 255;
    localparam int DEPTH = 4096;
    typedef struct {int addr; int data; int due;} exp_t;
    logic        clk = 1'b0, res = 1'b0, wrEn = 1'b0, clear_start = 1'b0;
    logic [1:0]  pix = '0, peak_pix = '0;
    logic [9:0]  data = '0;
    logic [7:0]  counts = '0;
    logic        ready, clear_done, readFlag, rEnable, writeFlag, wEnable, sat;
    logic [11:0] raddr, waddr;
    logic [7:0]  newCounts, peak_count;
    logic [9:0]  peak_bin;
    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    logic [7:0]  mem [DEPTH];
    int          ref_h [DEPTH];
    int          pk_cnt [4];
    int          pk_bin [4];
    bit          exp_sat;

    sifh_hist_rmw dut (
        .i_clk(clk), .i_res(res), .i_wrEn(wrEn), .i_pix(pix), .i_data(data),
        .o_ready(ready), .i_clear_start(clear_start), .o_clear_done(clear_done),
        .o_raddr(raddr), .o_readFlag(readFlag), .o_rEnable(rEnable), .i_counts(counts),
        .o_waddr(waddr), .o_writeFlag(writeFlag), .o_wEnable(wEnable), .o_newCounts(newCounts),
        .o_sat(sat), .i_peak_pix(peak_pix), .o_peak_bin(peak_bin), .o_peak_count(peak_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External dual-port RAM: 1-cycle read, read-first on collision
    always @(posedge clk) begin
        if (readFlag && !rEnable) counts <= mem[raddr];
        if (writeFlag && wEnable) mem[waddr] <= newCounts;
    end

    // Write-port monitor against the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (writeFlag) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0h data=%0d", waddr, newCounts);
            end else begin
                e = q.pop_front();
                if (waddr !== 12'(e.addr) || newCounts !== 8'(e.data) || wEnable !== 1'b1 || (e.due >= 0 && cyc != e.due)) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%0d wen=%0b cyc=%0d expected addr=%0h data=%0d cyc=%0d",
                             waddr, newCounts, wEnable, cyc, e.addr, e.data, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_clears();
        exp_t e;
        for (int k = 0; k < DEPTH; k++) begin
            e = '{k, 0, -1};
            q.push_back(e);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) ref_h[k] = 0;
        for (int p = 0; p < 4; p++) begin
            pk_cnt[p] = 0;
            pk_bin[p] = 0;
        end
        exp_sat = 1'b0;
    endtask

    task automatic ev(input int p, input int b);
        int a;
        exp_t e;
        a = p * 1024 + b;
        wrEn = 1'b1;
        pix  = 2'(p);
        data = 10'(b);
        if (ref_h[a] == PM) exp_sat = 1'b1;
        else ref_h[a]++;
        e = '{a, ref_h[a], cyc + 3};
        q.push_back(e);
        if (ref_h[a] > pk_cnt[p]) begin
            pk_cnt[p] = ref_h[a];
            pk_bin[p] = b;
        end
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        chk("raddr", int'(raddr), a);
        chk("readFlag", int'(readFlag), 1);
    endtask

    task automatic wait_done(output int n);
        int  rdy;
        bit  seen;
        n = 0;
        rdy = 0;
        seen = 1'b0;
        while (!seen && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (clear_done) seen = 1'b1;
            else if (ready) rdy++;
        end
        chk("clear_done_seen", int'(seen), 1);
        chk("ready_during_clear", rdy, 0);
        chk("ready_after_clear", int'(ready), 1);
        @(posedge clk);
        #1;
        chk("clear_done_pulse", int'(clear_done), 0);
    endtask

    task automatic check_peaks();
        for (int p = 0; p < 4; p++) begin
            peak_pix = 2'(p);
            @(posedge clk);
            #1;
            chk($sformatf("peak_bin_pix%0d", p), int'(peak_bin), pk_bin[p]);
            chk($sformatf("peak_count_pix%0d", p), int'(peak_count), pk_cnt[p]);
        end
    endtask

    initial begin
        int n;
        int pool [4];
        pool = '{7, 8, 513, 1023};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 0);
        chk("rst_clear_done", int'(clear_done), 0);
        chk("rst_readFlag", int'(readFlag), 0);
        chk("rst_rEnable", int'(rEnable), 1);
        chk("rst_writeFlag", int'(writeFlag), 0);
        chk("rst_wEnable", int'(wEnable), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_newCounts", int'(newCounts), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_peak_bin", int'(peak_bin), 0);
        chk("rst_peak_count", int'(peak_count), 0);
        model_clear();
        push_clears();
        res = 1'b1;
        wait_done(n);
        chk("sweep_cycles", n, DEPTH + 1);
        ev(1, 108);
        ev(0, 1022);
        ev(0, 1022);
        ev(0, 1022);
        idle(2);
        ev(0, 1022);
        idle(4);
        mem[3 * 1024 + 5] = 8'd254;
        ref_h[3 * 1024 + 5] = 254;
        ev(3, 5);
        idle(4);
        chk("sat_after_first_hit", int'(sat), int'(exp_sat));
        ev(3, 5);
        idle(4);
        chk("sat_after_second_hit", int'(sat), int'(exp_sat));
        repeat (3) ev(2, 200);
        repeat (3) ev(2, 90);
        idle(4);
        peak_pix = 2'd2;
        @(posedge clk);
        #1;
        chk("tie_peak_bin", int'(peak_bin), pk_bin[2]);
        chk("tie_peak_count", int'(peak_count), pk_cnt[2]);
        for (int i = 0; i < 400; i++) begin
            ev($urandom_range(0, 3), ($urandom_range(0, 4) == 4) ? $urandom_range(0, 1023) : pool[$urandom_range(0, 3)]);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        check_peaks();
        chk("sat_after_random", int'(sat), int'(exp_sat));
        ev(1, 7);
        ev(2, 8);
        clear_start = 1'b1;
        wrEn = 1'b1;
        pix = 2'd0;
        data = 10'd3;
        #1;
        chk("ready_on_clear_start", int'(ready), 0);
        push_clears();
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        wrEn = 1'b0;
        model_clear();
        wait_done(n);
        chk("drain_sweep_cycles", n, DEPTH + 4);
        chk("sat_after_clear", int'(sat), 0);
        check_peaks();
        ev(3, 5);
        idle(4);
        clear_start = 1'b1;
        push_clears();
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        idle(300);
        res = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_in_reset", int'(ready), 0);
        chk("writeFlag_in_reset", int'(writeFlag), 0);
        q.delete();
        @(posedge clk);
        #1;
        model_clear();
        push_clears();
        res = 1'b1;
        wait_done(n);
        chk("restart_sweep_cycles", n, DEPTH + 1);
        ev(0, 1022);
        ev(0, 1022);
        idle(4);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sifh_hist_rmw.md
# sifh_hist_rmw

Parametrised multi-pixel single-photon histogram engine for the SiFH datapath. Accepts one timestamp per cycle tagged with a pixel index and performs a pipelined read-modify-write increment on an external dual-port histogram RAM. Adds same-bin hazard forwarding, saturating counts, an automatic clear sweep and per-pixel running peak tracking. Sits between the TDC/photon front end and the histogram RAM; peak results feed the depth-extraction stage.

## Interface

- `NP`, 10, timestamp width.
- `NB`, 10, bin-address width; bin = `data[NP-1 -: NB]` (requires `NB <= NP`).
- `PEAK_MAX`, 8, count width.
- `PIXELS`, 4, pixel channels sharing one RAM; `PB = max(1, $clog2(PIXELS))`.
- `clk` in 1: single clock.
- `res` in 1: synchronous, active-low reset.
- `wrEn` in 1: photon event valid.
- `pix` in PB: pixel index of event.
- `data` in NP: timestamp.
- `ready` out 1: engine accepts events; an event is taken when `wrEn & ready`.
- `clear_start` in 1: pulse, request histogram and peak clear.
- `clear_done` out 1: one-cycle pulse at end of sweep.
- `raddr` out PB+NB: port-B address `{pix, bin}`.
- `readFlag` out 1: port-B memory enable, active-high.
- `rEnable` out 1: port-B read enable, active-low (`~readFlag`).
- `counts` in PEAK_MAX: port-B read data, one cycle after address.
- `waddr` out PB+NB: port-A address.
- `writeFlag` out 1: port-A memory enable.
- `wEnable` out 1: port-A write enable, active-high.
- `newCounts` out PEAK_MAX: port-A write data.
- `sat` out 1: sticky, a bin hit `2^PEAK_MAX-1`.
- `peak_pix` in PB: pixel selector for peak readout.
- `peak_bin` out NB, `peak_count` out PEAK_MAX: registered peak of selected pixel.

## Operation

- RAM contract: 1-cycle read latency, read-first on same-address read/write.
- States: CLEAR, RUN, DRAIN.
  - CLEAR: `ready=0`. Writes 0 to address 0..`PIXELS*2^NB-1`, one per cycle. Zeroes all peak registers and `sat`. After the last write, pulses `clear_done` and goes to RUN.
  - RUN: `ready=1`. `clear_start` goes to DRAIN and drops `ready` the same cycle; an event coincident with `clear_start` is rejected.
  - DRAIN: waits until pipeline valids R, M, W are all clear, then goes to CLEAR.
- Reset enters CLEAR, so histograms always start at zero.
- Pipeline stages:
  - R: register event and drive `raddr`/`readFlag`.
  - M: `counts` valid; `base` = forward from W if W valid and address equal, else from W2 (previous write) if valid and address equal, else `counts`.
  - W: drive `newCounts = (base == 2^PEAK_MAX-1) ? base : base+1`, with `writeFlag` and `wEnable` high.
- Saturation: a saturated increment sets `sat`; `sat` is cleared only by CLEAR.
- Peak tracker (W stage): per pixel, update `{peak_bin, peak_count}` when `newCounts > peak_count` (strict compare; the earliest bin wins ties).
- Peak readout: `peak_bin`/`peak_count` register the entry selected by `peak_pix` each cycle.
- Reset mid-operation: all stage valids clear, any in-flight write is suppressed, and the FSM returns to CLEAR.

## Timing

- Event accepted at edge e0:
  - `raddr`/`readFlag` valid in cycle e0–e1.
  - `counts` sampled during e1–e2.
  - `waddr`/`newCounts`/`writeFlag` valid in e2–e3; RAM written at e3.
- Latency is 3 cycles, throughput 1 event/cycle, with no stalls in RUN.
- Two-deep forwarding (W, W2) covers events to the same bin at distances 1 and 2; distance ≥3 reads fresh RAM.
- Peak readout latency: 1 cycle from `peak_pix`; reflects writes completed by the previous edge.
- Reset values:
  - `ready` 0; `clear_done` 0; `readFlag` 0; `rEnable` 1; `writeFlag` 0; `wEnable` 0.
  - `raddr`, `waddr`, `newCounts` 0.
  - `sat` 0; `peak_bin`, `peak_count` 0.
  - FSM in CLEAR, sweep counter 0.
- CLEAR duration: `PIXELS*2^NB` cycles plus 1 for `clear_done`.
- `clear_start` outside RUN is ignored.

## Structure

- Package `sifh_pkg`:
  - default `NP`/`NB`/`PEAK_MAX`/`PIXELS`;
  - state enum {CLEAR, RUN, DRAIN};
  - pipeline-stage struct {valid, addr, count};
  - saturating-increment function.
- One sub-module, `sifh_peak_tracker`: per-pixel peak register bank with update port and registered readout mux.

## Test plan

- Reset low 2 cycles, then high -> `ready` 0 for 4096 cycles with `waddr` 0..4095 and `newCounts` 0; `clear_done` pulses once; then `ready` 1.
- Single event `pix=1`, `data=108` -> `raddr=0x46C` one cycle later; `waddr=0x46C`, `newCounts=1` two cycles after that.
- Three back-to-back events `pix=0`, `data=1022` -> writes 1, 2, 3 to 0x3FE; then a fourth event 3 cycles later reads RAM and writes 4.
- Bin preloaded to 254, two hits -> `newCounts` 255 then 255; `sat` rises on the second hit.
- Pixel 2 gets hits on bins 200 ×3 and 90 ×3 -> with `peak_pix=2`: `peak_bin=200`, `peak_count=3` (tie keeps first).
- `clear_start` with events in flight -> in-flight writes complete; then a 4096-cycle sweep; `peak_count` 0 and `sat` 0 afterwards; `res` low mid-sweep restarts the sweep at address 0.
